// File: rtl/rename_stage.sv
// rename_stage: single-wide register rename.
// Sources and dest go through a speculative RAT. A new phys dest is popped
// from the free list. The renamed uop is sent to dispatch/ROB together with
// the old phys dest of rd, which the ROB frees at commit. A committed RAT is
// updated at retirement. On flush, the speculative RAT is rebuilt from the
// committed RAT.
module rename_stage #(
    parameter int NUM_PHYS_REGS = 64,
    parameter int PHYS_REG_BITS = 6,
    parameter int NUM_ARCH_REGS = 32,
    parameter int ARCH_REG_BITS = 5
) (
    input  logic                     clk,
    input  logic                     rst,

    // Decoded uop in
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ARCH_REG_BITS-1:0] in_rs1,
    input  logic [ARCH_REG_BITS-1:0] in_rs2,
    input  logic [ARCH_REG_BITS-1:0] in_rd,
    input  logic                     in_rd_wen,

    // Free list head
    output logic                     fl_alloc_en,
    input  logic [PHYS_REG_BITS-1:0] fl_alloc_reg,
    input  logic                     fl_alloc_valid,

    // Renamed uop out
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PHYS_REG_BITS-1:0] out_prs1,
    output logic [PHYS_REG_BITS-1:0] out_prs2,
    output logic [PHYS_REG_BITS-1:0] out_prd,
    output logic [PHYS_REG_BITS-1:0] out_old_prd,
    output logic                     out_rd_wen,

    // Retirement and recovery
    input  logic                     commit_en,
    input  logic [ARCH_REG_BITS-1:0] commit_rd,
    input  logic [PHYS_REG_BITS-1:0] commit_prd,
    input  logic                     flush
);

    typedef logic [PHYS_REG_BITS-1:0] tag_t;

    // Rename tables. Entry 0 is never written, so x0 stays mapped to phys 0.
    tag_t r_spec_rat   [NUM_ARCH_REGS];
    tag_t r_commit_rat [NUM_ARCH_REGS];
    tag_t w_commit_rat_next [NUM_ARCH_REGS];

    // Output register slice
    logic r_out_valid;
    tag_t r_out_prs1;
    tag_t r_out_prs2;
    tag_t r_out_prd;
    tag_t r_out_old_prd;
    logic r_out_rd_wen;

    logic w_need_alloc;
    logic w_commit_wr;
    logic w_in_ready;
    logic w_fire;

    // Writes to x0 are discarded. They neither allocate nor remap.
    assign w_need_alloc = in_rd_wen && (in_rd != '0);
    assign w_commit_wr  = commit_en && (commit_rd != '0);

    // Accept a uop only when:
    //   - no flush is pending,
    //   - the output slot is free or is draining this cycle, and
    //   - a free tag is available, if this uop needs one.
    // Uops that do not write rd still pass while the free list is empty.
    assign w_in_ready = !rst && !flush
                      && (!r_out_valid || out_ready)
                      && (!w_need_alloc || fl_alloc_valid);
    assign w_fire     = in_valid && w_in_ready;

    assign in_ready    = w_in_ready;
    assign fl_alloc_en = w_fire && w_need_alloc;

    // Committed RAT with this cycle's retirement applied; also the flush source
    always_comb begin
        // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
        w_commit_rat_next = r_commit_rat;
        if (w_commit_wr) begin
            w_commit_rat_next[commit_rd] = commit_prd;
        end
    end

    // Committed RAT register: follows retirement only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the RAT arrays are reset entry by entry, because the identity map is
            // architectural state that the core depends on. These arrays are flops, not a RAM
            // macro, so a reset is legal here.
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                r_commit_rat[i] <= tag_t'(i % NUM_PHYS_REGS);
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_commit_rat <= w_commit_rat_next;
        end
    end

    // Speculative RAT: rebuilt on flush, else remapped on a firing write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                r_spec_rat[i] <= tag_t'(i % NUM_PHYS_REGS);
            end
        end else if (flush) begin
            r_spec_rat <= w_commit_rat_next;
        end else if (w_fire && w_need_alloc) begin
            r_spec_rat[in_rd] <= fl_alloc_reg;
        end
    end

    // Output valid: set by fire, cleared by drain or flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Output payload: loaded on fire, held otherwise.
    // RAT reads see the mapping before this uop's own update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_prs1    <= '0;
            r_out_prs2    <= '0;
            r_out_prd     <= '0;
            r_out_old_prd <= '0;
            r_out_rd_wen  <= 1'b0;
        end else if (w_fire) begin
            r_out_prs1    <= r_spec_rat[in_rs1];
            r_out_prs2    <= r_spec_rat[in_rs2];
            r_out_old_prd <= r_spec_rat[in_rd];
            r_out_prd     <= w_need_alloc ? fl_alloc_reg : '0;
            r_out_rd_wen  <= w_need_alloc;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_prs1    = r_out_prs1;
    assign out_prs2    = r_out_prs2;
    assign out_prd     = r_out_prd;
    assign out_old_prd = r_out_old_prd;
    assign out_rd_wen  = r_out_rd_wen;

endmodule

// File: tb/tb_rename_stage.sv
// Testbench for rename_stage. The bench has three parts:
//   - a table of directed vectors,
//   - hand-written stall, flush and reset sequences,
//   - randomized traffic checked against an array-based RAT model.
module tb_rename_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_rs1, in_rs2, in_rd;
    logic       in_rd_wen;
    logic       fl_alloc_en;
    logic [5:0] fl_alloc_reg;
    logic       fl_alloc_valid;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_prs1, out_prs2, out_prd, out_old_prd;
    logic       out_rd_wen;
    logic       commit_en;
    logic [4:0] commit_rd;
    logic [5:0] commit_prd;
    logic       flush;

    int n_tests = 0;
    int n_fail  = 0;

    rename_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
        .fl_alloc_en(fl_alloc_en), .fl_alloc_reg(fl_alloc_reg), .fl_alloc_valid(fl_alloc_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd),
        .out_old_prd(out_old_prd), .out_rd_wen(out_rd_wen),
        .commit_en(commit_en), .commit_rd(commit_rd), .commit_prd(commit_prd),
        .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       wen;
        logic [5:0] alloc_reg;
        logic       alloc_valid;
        logic       exp_ready, exp_alloc_en, exp_valid;
        logic [5:0] exp_prs1, exp_prs2, exp_prd, exp_old;
        logic       exp_rd_wen;
    } vec_t;

    vec_t vecs[7];

    // Reference model state
    int m_spec[32];
    int m_commit[32];
    bit m_ov;
    int m_prs1, m_prs2, m_prd, m_old, m_rdw;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_wen = 0;
        fl_alloc_reg = 0; fl_alloc_valid = 1; out_ready = 1;
        commit_en = 0; commit_rd = 0; commit_prd = 0; flush = 0;
    endtask

    task automatic set_uop(input int rs1, input int rs2, input int rd, input bit wen,
                           input int alloc, input bit av);
        in_valid = 1; in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_rd = 5'(rd);
        in_rd_wen = wen; fl_alloc_reg = 6'(alloc); fl_alloc_valid = av;
    endtask

    initial begin
        // Directed vectors. Each is applied for one cycle with out_ready=1.
        // Expected values are worked out by hand from the running mapping.
        //              rs1 rs2 rd wen alloc av  rdy en  val prs1 prs2 prd old rdw
        vecs[0] = '{5'd1, 5'd2, 5'd5, 1, 6'd32, 1, 1, 1, 1, 6'd1,  6'd2,  6'd32, 6'd5,  1};
        vecs[1] = '{5'd5, 5'd1, 5'd6, 1, 6'd33, 1, 1, 1, 1, 6'd32, 6'd1,  6'd33, 6'd6,  1};
        vecs[2] = '{5'd6, 5'd5, 5'd0, 1, 6'd34, 1, 1, 0, 1, 6'd33, 6'd32, 6'd0,  6'd0,  0};
        vecs[3] = '{5'd7, 5'd0, 5'd7, 1, 6'd34, 0, 0, 0, 0, 6'd0,  6'd0,  6'd0,  6'd0,  0};
        vecs[4] = '{5'd7, 5'd6, 5'd9, 0, 6'd34, 0, 1, 0, 1, 6'd7,  6'd33, 6'd0,  6'd9,  0};
        vecs[5] = '{5'd5, 5'd5, 5'd5, 1, 6'd35, 1, 1, 1, 1, 6'd32, 6'd32, 6'd35, 6'd32, 1};
        vecs[6] = '{5'd5, 5'd0, 5'd0, 0, 6'd36, 1, 1, 0, 1, 6'd35, 6'd0,  6'd0,  6'd0,  0};

        set_idle();
        rst = 1;
        #2;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_prd", int'(out_prd), 0);
        check("rst_old_prd", int'(out_old_prd), 0);
        tick();
        tick();
        rst = 0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 7; i++) begin
            set_uop(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wen,
                    vecs[i].alloc_reg, vecs[i].alloc_valid);
            #1;
            check($sformatf("v%0d_in_ready", i), int'(in_ready), int'(vecs[i].exp_ready));
            check($sformatf("v%0d_alloc_en", i), int'(fl_alloc_en), int'(vecs[i].exp_alloc_en));
            tick();
            check($sformatf("v%0d_out_valid", i), int'(out_valid), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_prs1", i), int'(out_prs1), int'(vecs[i].exp_prs1));
                check($sformatf("v%0d_prs2", i), int'(out_prs2), int'(vecs[i].exp_prs2));
                check($sformatf("v%0d_prd", i), int'(out_prd), int'(vecs[i].exp_prd));
                check($sformatf("v%0d_old_prd", i), int'(out_old_prd), int'(vecs[i].exp_old));
                check($sformatf("v%0d_rd_wen", i), int'(out_rd_wen), int'(vecs[i].exp_rd_wen));
            end
        end

        // ---------------- backpressure hold ----------------
        set_idle();
        tick();
        check("drain_out_valid", int'(out_valid), 0);
        set_uop(5, 6, 10, 1, 40, 1);
        out_ready = 0;
        #1;
        check("bp_first_ready", int'(in_ready), 1);
        tick();
        set_uop(10, 0, 11, 1, 41, 1);
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_alloc_en", int'(fl_alloc_en), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_prs1", int'(out_prs1), 35);
            check("bp_prs2", int'(out_prs2), 33);
            check("bp_prd", int'(out_prd), 40);
            check("bp_old_prd", int'(out_old_prd), 10);
            tick();
        end
        out_ready = 1;
        #1;
        check("bp_release_ready", int'(in_ready), 1);
        check("bp_release_alloc", int'(fl_alloc_en), 1);
        tick();
        check("bp_next_prs1", int'(out_prs1), 40);
        check("bp_next_prd", int'(out_prd), 41);
        check("bp_next_old", int'(out_old_prd), 11);
        set_idle();
        tick();
        check("bp_drained", int'(out_valid), 0);

        // ---------------- flush with same-cycle commit ----------------
        commit_en = 1; commit_rd = 5; commit_prd = 32;
        set_uop(0, 0, 5, 1, 50, 1);
        #1;
        check("fl_pre_alloc", int'(fl_alloc_en), 1);
        tick();
        commit_rd = 6; commit_prd = 51; flush = 1;
        set_uop(0, 0, 7, 1, 52, 1);
        #1;
        check("fl_in_ready", int'(in_ready), 0);
        check("fl_alloc_en", int'(fl_alloc_en), 0);
        tick();
        check("fl_out_valid", int'(out_valid), 0);
        flush = 0; commit_en = 0;
        set_uop(5, 6, 0, 0, 0, 1);
        tick();
        check("fl_x5", int'(out_prs1), 32);
        check("fl_x6", int'(out_prs2), 51);
        set_uop(10, 11, 0, 0, 0, 1);
        tick();
        check("fl_x10", int'(out_prs1), 10);
        check("fl_x11", int'(out_prs2), 11);

        // ---------------- reset in the middle of traffic ----------------
        set_uop(3, 4, 12, 1, 60, 1);
        tick();
        check("mr_out_valid_before", int'(out_valid), 1);
        rst = 1;
        #1;
        check("mr_out_valid", int'(out_valid), 0);
        check("mr_out_prd", int'(out_prd), 0);
        check("mr_in_ready", int'(in_ready), 0);
        check("mr_alloc_en", int'(fl_alloc_en), 0);
        tick();
        rst = 0;
        set_idle();

        // ---------------- randomized traffic vs model ----------------
        for (int i = 0; i < 32; i++) begin
            m_spec[i] = i;
            m_commit[i] = i;
        end
        m_ov = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit need, exp_ready, fire;
            in_valid       = ($urandom_range(0, 3) != 0);
            in_rs1         = 5'($urandom_range(0, 31));
            in_rs2         = 5'($urandom_range(0, 31));
            in_rd          = 5'($urandom_range(0, 31));
            in_rd_wen      = ($urandom_range(0, 4) != 0);
            fl_alloc_reg   = 6'($urandom_range(0, 63));
            fl_alloc_valid = ($urandom_range(0, 4) != 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            commit_en      = ($urandom_range(0, 2) == 0);
            commit_rd      = 5'($urandom_range(0, 31));
            commit_prd     = 6'($urandom_range(0, 63));
            flush          = ($urandom_range(0, 19) == 0);

            need      = in_rd_wen && (in_rd != 0);
            exp_ready = !flush && (!m_ov || out_ready) && (!need || fl_alloc_valid);
            fire      = in_valid && exp_ready;
            #1;
            check("rnd_in_ready", int'(in_ready), int'(exp_ready));
            check("rnd_alloc_en", int'(fl_alloc_en), int'(fire && need));

            if (commit_en && commit_rd != 0) m_commit[commit_rd] = int'(commit_prd);
            if (flush) begin
                m_spec = m_commit;
                m_ov = 0;
            end else if (fire) begin
                m_ov   = 1;
                m_prs1 = m_spec[in_rs1];
                m_prs2 = m_spec[in_rs2];
                m_old  = m_spec[in_rd];
                m_prd  = need ? int'(fl_alloc_reg) : 0;
                m_rdw  = int'(need);
                if (need) m_spec[in_rd] = int'(fl_alloc_reg);
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end

            tick();
            check("rnd_out_valid", int'(out_valid), int'(m_ov));
            if (m_ov) begin
                check("rnd_prs1", int'(out_prs1), m_prs1);
                check("rnd_prs2", int'(out_prs2), m_prs2);
                check("rnd_prd", int'(out_prd), m_prd);
                check("rnd_old_prd", int'(out_old_prd), m_old);
                check("rnd_rd_wen", int'(out_rd_wen), m_rdw);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
